// File: rtl/synth_pkg.sv
// synth_pkg: MIDI constants and parser state shared by the synth blocks
package synth_pkg;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_PROG     = 4'hC;
  localparam logic [3:0] MIDI_CHPRESS  = 4'hD;
  localparam logic [7:0] MIDI_SYSEX    = 8'hF0;
  localparam logic [7:0] MIDI_EOX      = 8'hF7;
  localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;
  typedef enum logic [1:0] {IDLE, D1, D2, SYSEX} midi_state_t;
endpackage

// File: rtl/midi_note_ctrl.sv
// midi_note_ctrl: monophonic MIDI note parser with running status driving gate/note/velocity
module midi_note_ctrl
  import synth_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       gate,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       note_on_pulse,
  output logic       note_off_pulse,
  output logic [7:0] msg_count
);
  midi_state_t state;
  logic [7:0] status;
  logic [6:0] d1;
  logic is_rt, is_chan, is_short, is_note, is_on, accept, hit;
  always_comb begin
    is_rt    = rx_data >= MIDI_RT_MIN;
    is_chan  = rx_data[7] && rx_data < MIDI_SYSEX;
    is_short = status[7:4] == MIDI_PROG || status[7:4] == MIDI_CHPRESS;
    is_note  = status[7:4] == MIDI_NOTE_ON || status[7:4] == MIDI_NOTE_OFF;
    is_on    = status[7:4] == MIDI_NOTE_ON && rx_data[6:0] != 7'd0;
    accept   = OMNI || status[3:0] == CHANNEL;
    hit      = rx_valid && !rx_data[7] && state == D2 && is_note && accept;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      status         <= '0;
      d1             <= '0;
      gate           <= 1'b0;
      note           <= '0;
      velocity       <= '0;
      note_on_pulse  <= 1'b0;
      note_off_pulse <= 1'b0;
      msg_count      <= '0;
    end else begin
      note_on_pulse  <= hit && is_on;
      note_off_pulse <= hit && !is_on && gate && d1 == note;
      if (hit) msg_count <= msg_count + 8'd1;
      if (hit && is_on) begin
        note     <= d1;
        velocity <= rx_data[6:0];
        gate     <= 1'b1;
      end else if (hit && gate && d1 == note) gate <= 1'b0;
      // real-time bytes fall through untouched, leaving any partial message intact
      if (rx_valid && !is_rt) begin
        if (is_chan) begin
          status <= rx_data;
          state  <= D1;
        end else if (rx_data[7]) begin
          status <= '0;
          state  <= rx_data == MIDI_SYSEX ? SYSEX : IDLE;
        end else if (state == D1) begin
          d1    <= rx_data[6:0];
          state <= is_short ? D1 : D2;
        end else if (state == D2) state <= D1;
      end
    end
  end
endmodule

// File: tb/tb_midi_note_ctrl.sv
// tb_midi_note_ctrl: directed byte sequences with hand-computed expectations on filtered and omni instances
module tb_midi_note_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic gate, on_p, off_p, gate_o, on_p_o, off_p_o;
  logic [6:0] note, velocity, note_o, velocity_o;
  logic [7:0] msg_count, msg_count_o;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  midi_note_ctrl #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .gate(gate), .note(note), .velocity(velocity),
    .note_on_pulse(on_p), .note_off_pulse(off_p), .msg_count(msg_count)
  );
  midi_note_ctrl #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .gate(gate_o), .note(note_o), .velocity(velocity_o),
    .note_on_pulse(on_p_o), .note_off_pulse(off_p_o), .msg_count(msg_count_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'hxx;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("rst_gate", gate, 0);
    chk("rst_note", note, 0);
    chk("rst_vel", velocity, 0);
    chk("rst_on_p", on_p, 0);
    chk("rst_off_p", off_p, 0);
    chk("rst_cnt", msg_count, 0);
    send(8'h90); send(8'h3C);
    chk("pre_on_p", on_p, 0);
    send(8'h64);
    chk("on_note", note, 7'h3C);
    chk("on_vel", velocity, 7'h64);
    chk("on_gate", gate, 1);
    chk("on_pulse", on_p, 1);
    chk("on_cnt", msg_count, 1);
    idle();
    chk("on_pulse_end", on_p, 0);
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h40); send(8'h50);
    chk("rs_note", note, 7'h40);
    chk("rs_vel", velocity, 7'h50);
    chk("rs_pulse", on_p, 1);
    send(8'h3C); send(8'h00);
    chk("rs_gate_held", gate, 1);
    chk("rs_off_p", off_p, 0);
    chk("rs_note_held", note, 7'h40);
    chk("rs_cnt", msg_count, 3);
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'hF8);
    chk("rt_on_p", on_p, 0);
    chk("rt_gate", gate, 1);
    send(8'h80); send(8'h3C);
    chk("off_pre_gate", gate, 1);
    send(8'h00);
    chk("off_gate", gate, 0);
    chk("off_pulse", off_p, 1);
    chk("off_vel", velocity, 7'h64);
    chk("off_note", note, 7'h3C);
    chk("off_cnt", msg_count, 2);
    idle();
    chk("off_pulse_end", off_p, 0);
    do_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    chk("ch_gate", gate, 0);
    chk("ch_pulse", on_p, 0);
    chk("ch_cnt", msg_count, 0);
    chk("omni_gate", gate_o, 1);
    chk("omni_note", note_o, 7'h3C);
    chk("omni_cnt", msg_count_o, 1);
    do_reset();
    send(8'h90); send(8'h3C); send(8'hC0); send(8'h05); send(8'h45); send(8'h10);
    chk("int_gate", gate, 0);
    chk("int_cnt", msg_count, 0);
    chk("int_gate_o", gate_o, 0);
    do_reset();
    send(8'hF0); send(8'h01); send(8'h90); send(8'h02); send(8'hF7); send(8'h3C); send(8'h64);
    chk("sx_gate", gate, 0);
    chk("sx_cnt", msg_count, 0);
    send(8'h90); send(8'h3C); send(8'h64);
    chk("sx_after_gate", gate, 1);
    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    chk("mr_gate", gate, 0);
    chk("mr_note", note, 0);
    chk("mr_vel", velocity, 0);
    chk("mr_on_p", on_p, 0);
    chk("mr_cnt", msg_count, 0);
    do_reset();
    send(8'h90);
    for (int i = 0; i < 255; i++) begin
      send(8'h3C); send(8'h64);
    end
    chk("wrap_ff", msg_count, 8'hFF);
    send(8'h3C); send(8'h64);
    chk("wrap_0", msg_count, 8'h00);
    chk("wrap_gate", gate, 1);
    chk("wrap_pulse", on_p, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/midi_note_ctrl.md
# midi_note_ctrl

Monophonic MIDI note controller for the synth. Consumes the byte stream from `uart_rx` (`data`/`data_valid`), parses MIDI channel-voice messages with running status, and drives the note/gate/velocity registers that configure the tone datapath and the seven-segment display. System real-time bytes pass through transparently; all other message types are parsed and discarded.

## Interface
- `CHANNEL`, default 0: MIDI channel (0–15) accepted when `OMNI`=0.
- `OMNI`, default 0: 1 = accept note messages on all channels.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle byte strobe; may assert on consecutive cycles.
- `gate`  out  1  note currently held.
- `note`  out  7  current/last note number.
- `velocity`  out  7  velocity of current/last note-on.
- `note_on_pulse`  out  1  one-cycle pulse on each accepted note-on, including retrigger.
- `note_off_pulse`  out  1  one-cycle pulse when `gate` falls.
- `msg_count`  out  8  count of accepted note messages; wraps 255→0.

## Operation
- Reset values: `gate`=0, `note`=0, `velocity`=0, both pulses 0, `msg_count`=0, state IDLE, running status cleared.
- Byte classes: data `<0x80`; channel status `0x80–0xEF`; system common `0xF0–0xF7`; real-time `0xF8–0xFF`.
- States:
  - IDLE: no running status.
  - D1: expecting first data byte.
  - D2: expecting second data byte.
  - SYSEX: inside a system-exclusive message.
- Stored status is 8 bits. Message type: `0x8n` note-off, `0x9n` note-on, other channel types are parsed but discarded.
- Real-time byte: ignored in every state; no state, data, or pulse change.
- Channel status byte, any state: store status, go to D1, discard any partial message.
- `0xF0`: go to SYSEX and clear running status.
- `0xF1–0xF7`: go to IDLE and clear running status. `0xF7` ends SYSEX.
- Data byte in IDLE or SYSEX: ignored.
- D1 + data: latch `d1`.
  - Types `0xC`/`0xD`: message complete, return to D1 (running status).
  - All other types: go to D2.
- D2 + data: message complete, return to D1 (running status).
  - Note-on with `d2`≠0: `note`←`d1`, `velocity`←`d2`, `gate`←1, `note_on_pulse`; applies even if `gate` is already 1 (retrigger).
  - Note-off, or note-on with `d2`=0: if `gate`=1 and `d1`==`note`, then `gate`←0 and `note_off_pulse`. Otherwise no output change. `note` and `velocity` are held.
- Channel filter: `status[3:0]`≠`CHANNEL` with `OMNI`=0 means the message is still parsed, but has no output effect and no count.
- `msg_count` increments on every completed, channel-accepted note message, including non-matching note-offs.

## Timing
- Outputs are registered. A completing data byte at cycle N (`rx_valid`=1) updates outputs and pulses at cycle N+1.
- Pulses are exactly one cycle wide. Back-to-back completions at N and N+1 give pulses at N+1 and N+2.
- Throughput: one byte per cycle, no backpressure, no byte dropped.
- Reset asserted mid-message: cleared on the next edge. Subsequent data bytes are ignored until a new status byte.
- `rx_data` is don't-care when `rx_valid`=0.

## Structure
- Shared package `synth_pkg` holds:
  - MIDI constants: `MIDI_NOTE_OFF`=4'h8, `MIDI_NOTE_ON`=4'h9, `MIDI_PROG`=4'hC, `MIDI_CHPRESS`=4'hD, `MIDI_SYSEX`=8'hF0, `MIDI_EOX`=8'hF7, `MIDI_RT_MIN`=8'hF8.
  - Parser state enum `midi_state_t`.
- Single module with no sub-module; byte classification is inline combinational logic.

## Test plan
- 90 3C 64 → `note`=0x3C, `velocity`=0x64, `gate`=1, one `note_on_pulse` one cycle after the 0x64 byte, `msg_count`=1.
- Running status: 90 3C 64 40 50 3C 00 → retrigger to `note`=0x40, `velocity`=0x50. The 3C 00 is a note-off for a non-current note, so `gate` stays 1; `msg_count`=3.
- 90 3C 64 F8 80 3C 00 → the F8 has no effect; after the final byte `gate`=0, one `note_off_pulse`, `velocity` held at 0x64.
- `CHANNEL`=0, `OMNI`=0: 91 3C 64 → no output change, `msg_count`=0. Same bytes with `OMNI`=1 → `gate`=1.
- Interruptions: 90 3C C0 05 45 10 → the partial note is discarded; program change consumed; running status C0 consumes 45 and 10; `gate` stays 0. F0 01 90 02 F7 3C 64 → 90 aborts SYSEX and the parser is in D1 when 02 arrives; F7 → IDLE; 3C 64 ignored.
- 90 3C with `rst_n` low one cycle, then 64 → ignored, all outputs at reset values. 256 accepted messages → `msg_count` wraps to 0.
